wptr_full_lvl: RTL

Write-domain pointer and status block for the async FIFO, replacing the fixed-offset almost-full write-pointer logic. It keeps a binary and a Gray write pointer and converts the synchronised Gray read pointer back to binary. From these it produces registered full, runtime-programmable almost-full, fill level, free count and a sticky overflow error. It sits between the write port/memory write address and the rptr→wclk 2-FF synchroniser.

---
 rtl/afifo_pkg.sv | 27 ++
 rtl/afifo_gray2bin.sv | 17 +
 rtl/wptr_full_lvl.sv | 109 ++++++++++
 3 files changed

// File: rtl/afifo_pkg.sv
// Shared helpers for the async FIFO pointer blocks (write and read side).
//   bin2gray / gray2bin : pointer code conversion. They work on a 32-bit
//                         container. Callers zero-extend narrower pointers
//                         and cast the result back to their own width;
//                         leading zeros do not change either conversion.
//   depth_of            : FIFO depth for a given memory address width.
package afifo_pkg;

  localparam int PTR_MAXW = 32;

  function automatic int depth_of(input int addrsize);
    return 1 << addrsize;
  endfunction

  function automatic logic [PTR_MAXW-1:0] bin2gray(input logic [PTR_MAXW-1:0] b);
    return (b >> 1) ^ b;
  endfunction

  // Each binary bit is the XOR of all Gray bits at and above its position.
  function automatic logic [PTR_MAXW-1:0] gray2bin(input logic [PTR_MAXW-1:0] g);
    logic [PTR_MAXW-1:0] b;
    b[PTR_MAXW-1] = g[PTR_MAXW-1];
    for (int i = PTR_MAXW-2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

endpackage

// File: rtl/afifo_gray2bin.sv
// Purely combinational Gray-to-binary converter of generic width.
// Used on the synchronised opposite-domain pointer in both the write-side
// and read-side status blocks.
//   gray_i : Gray-coded pointer
//   bin_o  : binary equivalent, bit i = XOR of gray_i[W-1:i]
module afifo_gray2bin #(
  parameter int W = 5
) (
  input  logic [W-1:0] gray_i,
  output logic [W-1:0] bin_o
);

  for (genvar i = 0; i < W; i++) begin : g_bit
    assign bin_o[i] = ^gray_i[W-1:i];
  end

endmodule

// File: rtl/wptr_full_lvl.sv
// Write-domain pointer and status block for the async FIFO.
// Holds the binary and Gray write pointers, converts the synchronised Gray
// read pointer back to binary, and registers full, programmable almost-full,
// fill level, free count and a sticky overflow flag.
//   wclk, wrst_n        : write clock, async active-low reset
//   winc                : write request, taken only while !wfull
//   wq2_rptr            : Gray read pointer already synchronised into wclk
//   awfull_thresh(_vld) : almost-full free-slot threshold and its load strobe
//   werr_clr            : clears the sticky overflow flag
//   waddr               : memory write address (low bits of binary pointer)
//   wptr                : Gray write pointer towards the read-side synchroniser
//   wfull, awfull       : full / free slots <= threshold (registered)
//   wlevel, wfree       : occupied / free words seen from this domain
//   werr                : sticky "write attempted while full"
module wptr_full_lvl
  import afifo_pkg::*;
#(
  parameter int ADDRSIZE   = 4,
  parameter int AWFULL_RST = 1
) (
  input  logic                wclk,
  input  logic                wrst_n,
  input  logic                winc,
  input  logic [ADDRSIZE:0]   wq2_rptr,
  input  logic [ADDRSIZE:0]   awfull_thresh,
  input  logic                awfull_thresh_vld,
  input  logic                werr_clr,
  output logic [ADDRSIZE-1:0] waddr,
  output logic [ADDRSIZE:0]   wptr,
  output logic                wfull,
  output logic                awfull,
  output logic [ADDRSIZE:0]   wlevel,
  output logic [ADDRSIZE:0]   wfree,
  output logic                werr
);

  localparam int PW = ADDRSIZE + 1;
  localparam logic [ADDRSIZE:0] DEPTH_V = PW'(depth_of(ADDRSIZE));
  // A reset threshold above DEPTH behaves exactly like DEPTH, so clamp it here.
  localparam logic [ADDRSIZE:0] THR_RST =
    (AWFULL_RST > depth_of(ADDRSIZE)) ? DEPTH_V : PW'(AWFULL_RST);

  logic [ADDRSIZE:0] wbin_q,   wbin_d;
  logic [ADDRSIZE:0] wgray_q,  wgray_d;
  logic [ADDRSIZE:0] lvl_q,    lvl_d;
  logic [ADDRSIZE:0] free_q,   free_d;
  logic [ADDRSIZE:0] thr_q,    thr_d;
  logic              wfull_q,  wfull_d;
  logic              awfull_q, awfull_d;
  logic              werr_q,   werr_d;
  logic [ADDRSIZE:0] rbin;
  logic              wacc;

  afifo_gray2bin #(.W(PW)) u_rptr_g2b (
    .gray_i (wq2_rptr),
    .bin_o  (rbin)
  );

  // The pointer advances by at most one per cycle, so wptr changes by a
  // single bit per edge and is safe to hand to the synchroniser.
  assign wacc    = winc & ~wfull_q;
  assign wbin_d  = wbin_q + PW'(wacc);
  assign wgray_d = PW'(bin2gray(32'(wbin_d)));

  // Modular subtraction keeps the level right across the pointer wrap.
  // rbin can only lag the true read pointer, so status errs towards fuller.
  assign lvl_d    = wbin_d - rbin;
  assign free_d   = DEPTH_V - lvl_d;
  assign wfull_d  = (lvl_d == DEPTH_V);
  assign awfull_d = (free_d <= thr_q);

  // Overflow set has priority over a simultaneous clear.
  assign werr_d = (winc & wfull_q) ? 1'b1 : (werr_clr ? 1'b0 : werr_q);

  // A new threshold is used for awfull from the edge after it is loaded.
  assign thr_d = awfull_thresh_vld ?
                 ((awfull_thresh > DEPTH_V) ? DEPTH_V : awfull_thresh) : thr_q;

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin_q   <= '0;
      wgray_q  <= '0;
      lvl_q    <= '0;
      free_q   <= DEPTH_V;
      wfull_q  <= 1'b0;
      awfull_q <= 1'b0;
      werr_q   <= 1'b0;
      thr_q    <= THR_RST;
    end else begin
      wbin_q   <= wbin_d;
      wgray_q  <= wgray_d;
      lvl_q    <= lvl_d;
      free_q   <= free_d;
      wfull_q  <= wfull_d;
      awfull_q <= awfull_d;
      werr_q   <= werr_d;
      thr_q    <= thr_d;
    end
  end

  assign waddr  = wbin_q[ADDRSIZE-1:0];
  assign wptr   = wgray_q;
  assign wfull  = wfull_q;
  assign awfull = awfull_q;
  assign wlevel = lvl_q;
  assign wfree  = free_q;
  assign werr   = werr_q;

endmodule
